// File: rtl/pci_io_regs_if.sv
// Pad-side PCI bus bundle: the IOBUF inputs (*_IN) and the registered drives (*_OUT, *_T).
interface pci_io_regs_if #(
    parameter int unsigned AD_WIDTH = 32,
    parameter int unsigned NCTL     = 5
);
    localparam int unsigned NLANE = AD_WIDTH / 32;
    localparam int unsigned CBE_W = AD_WIDTH / 8;

    logic [AD_WIDTH-1:0] AD_IN;
    logic [AD_WIDTH-1:0] AD_OUT;
    logic                AD_T;

    logic [CBE_W-1:0]    CBE_IN;
    logic [CBE_W-1:0]    CBE_OUT;
    logic                CBE_T;

    logic [NLANE-1:0]    PAR_IN;
    logic [NLANE-1:0]    PAR_OUT;
    logic                PAR_T;

    logic [NCTL-1:0]     CTL_IN;
    logic [NCTL-1:0]     CTL_OUT;
    logic [NCTL-1:0]     CTL_T;

    logic                PERR_IN;
    logic                PERR_OUT;
    logic                PERR_T;

    // Register stage side: samples pads, drives outputs and tri-state controls
    modport master (
        input  AD_IN, CBE_IN, PAR_IN, CTL_IN, PERR_IN,
        output AD_OUT, AD_T, CBE_OUT, CBE_T, PAR_OUT, PAR_T,
        output CTL_OUT, CTL_T, PERR_OUT, PERR_T
    );

    // Pad / IOBUF side
    modport slave (
        output AD_IN, CBE_IN, PAR_IN, CTL_IN, PERR_IN,
        input  AD_OUT, AD_T, CBE_OUT, CBE_T, PAR_OUT, PAR_T,
        input  CTL_OUT, CTL_T, PERR_OUT, PERR_T
    );
endinterface

// File: rtl/pci_io_regs.sv
// PCI pad-register stage: registers all pad inputs/outputs, generates PAR one clock
// after AD, parks sustained-tri-state controls for one clock, and checks received parity.
module pci_io_regs #(
    parameter int unsigned AD_WIDTH  = 32,
    parameter int unsigned NCTL      = 5,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,

    pci_io_regs_if.master             pad,

    output logic [AD_WIDTH-1:0]       AD_I,
    output logic [AD_WIDTH/8-1:0]     CBE_I_N,
    output logic [AD_WIDTH/32-1:0]    PAR_I,
    output logic [NCTL-1:0]           CTL_I_N,
    output logic                      PERR_I_N,

    input  logic [AD_WIDTH-1:0]       AD_O,
    input  logic                      OE_AD_N,
    input  logic [AD_WIDTH/8-1:0]     CBE_O_N,
    input  logic                      OE_CBE_N,
    input  logic [NCTL-1:0]           CTL_O_N,
    input  logic [NCTL-1:0]           OE_CTL_N,

    input  logic                      PAR_CHK_EN,
    input  logic                      PERR_EN,
    input  logic                      PERR_CNT_CLR,
    output logic                      PERR_DET,
    output logic [CNT_WIDTH-1:0]      PERR_CNT
);
    localparam int unsigned NLANE = AD_WIDTH / 32;
    localparam int unsigned CBE_W = AD_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        CTL_FLOAT = 2'd0,
        CTL_DRIVE = 2'd1,
        CTL_PARK  = 2'd2
    } ctl_st_e;

    // Even parity per 32-bit lane over AD and its four byte enables
    function automatic logic [NLANE-1:0] lane_par(input logic [AD_WIDTH-1:0] ad,
                                                  input logic [CBE_W-1:0]    cbe);
        logic [NLANE-1:0] p;
        p = '0;
        for (int k = 0; k < int'(NLANE); k++) begin
            p[k] = ^{ad[32*k +: 32], cbe[4*k +: 4]};
        end
        return p;
    endfunction

    // Input capture registers
    logic [AD_WIDTH-1:0] ad_i_q, ad_i_d;
    logic [CBE_W-1:0]    cbe_i_q, cbe_i_d;
    logic [NLANE-1:0]    par_i_q, par_i_d;
    logic [NCTL-1:0]     ctl_i_q, ctl_i_d;
    logic                perr_i_q, perr_i_d;

    // Output / enable registers and parity generation
    logic [AD_WIDTH-1:0] ad_out_q, ad_out_d;
    logic                ad_t_q, ad_t_d;
    logic [CBE_W-1:0]    cbe_out_q, cbe_out_d;
    logic                cbe_t_q, cbe_t_d;
    logic [NLANE-1:0]    par_out_q, par_out_d;
    logic                par_t_q, par_t_d;

    // Sustained-tri-state control lines
    ctl_st_e             ctl_st_q [NCTL];
    ctl_st_e             ctl_st_d [NCTL];
    logic [NCTL-1:0]     ctl_out_q, ctl_out_d;
    logic [NCTL-1:0]     ctl_t_q, ctl_t_d;

    // Parity check pipeline and PERR# drive
    logic                chk_vld_q, chk_vld_d;
    logic [NLANE-1:0]    chk_par_q, chk_par_d;
    logic                perr_det_q, perr_det_d;
    logic [CNT_WIDTH-1:0] perr_cnt_q, perr_cnt_d;
    logic                perr_out_q, perr_out_d;
    logic                perr_t_q, perr_t_d;
    logic                perr_drv;

    // Datapath next values: pad capture, core output capture, PAR one clock behind AD
    always_comb begin
        ad_i_d    = pad.AD_IN;
        cbe_i_d   = pad.CBE_IN;
        par_i_d   = pad.PAR_IN;
        ctl_i_d   = pad.CTL_IN;
        perr_i_d  = pad.PERR_IN;

        ad_out_d  = AD_O;
        ad_t_d    = OE_AD_N;
        cbe_out_d = CBE_O_N;
        cbe_t_d   = OE_CBE_N;

        par_out_d = lane_par(ad_out_q, cbe_out_q);
        par_t_d   = ad_t_q;
    end

    // Control-line FSM next state; output flops follow the next state so T/OUT are registered
    always_comb begin
        ctl_out_d = '1;
        ctl_t_d   = '1;
        for (int i = 0; i < int'(NCTL); i++) begin
            ctl_st_d[i] = ctl_st_q[i];
            case (ctl_st_q[i])
                CTL_FLOAT: if (!OE_CTL_N[i]) ctl_st_d[i] = CTL_DRIVE;
                CTL_DRIVE: if (OE_CTL_N[i])  ctl_st_d[i] = CTL_PARK;
                CTL_PARK:  ctl_st_d[i] = OE_CTL_N[i] ? CTL_FLOAT : CTL_DRIVE;
                default:   ctl_st_d[i] = CTL_FLOAT;
            endcase
            case (ctl_st_d[i])
                CTL_DRIVE: begin
                    ctl_t_d[i]   = 1'b0;
                    ctl_out_d[i] = CTL_O_N[i];
                end
                CTL_PARK: begin
                    ctl_t_d[i]   = 1'b0;
                    ctl_out_d[i] = 1'b1;
                end
                default: begin
                    ctl_t_d[i]   = 1'b1;
                    ctl_out_d[i] = 1'b1;
                end
            endcase
        end
    end

    // Parity check: latch expected parity with the data phase, compare against PAR one clock later
    always_comb begin
        chk_vld_d  = PAR_CHK_EN;
        chk_par_d  = lane_par(ad_i_q, cbe_i_q);
        perr_det_d = chk_vld_q & (|(chk_par_q ^ par_i_q));

        perr_cnt_d = perr_cnt_q;
        if (PERR_CNT_CLR) begin
            perr_cnt_d = '0;
        end else if (perr_det_d && (perr_cnt_q != CNT_MAX)) begin
            perr_cnt_d = perr_cnt_q + CNT_WIDTH'(1);
        end

        // Low while errors keep coming, one park-high clock after the last one
        perr_drv   = perr_det_d & PERR_EN;
        perr_out_d = ~perr_drv;
        perr_t_d   = ~(perr_drv | ~perr_out_q);
    end

    // Datapath and parity registers with idle-bus reset values
    always_ff @(posedge CLK) begin
        if (RST) begin
            ad_i_q     <= '1;
            cbe_i_q    <= '1;
            par_i_q    <= '1;
            ctl_i_q    <= '1;
            perr_i_q   <= 1'b1;
            ad_out_q   <= '0;
            ad_t_q     <= 1'b1;
            cbe_out_q  <= '1;
            cbe_t_q    <= 1'b1;
            par_out_q  <= '0;
            par_t_q    <= 1'b1;
            chk_vld_q  <= 1'b0;
            chk_par_q  <= '0;
            perr_det_q <= 1'b0;
            perr_cnt_q <= '0;
            perr_out_q <= 1'b1;
            perr_t_q   <= 1'b1;
        end else begin
            ad_i_q     <= ad_i_d;
            cbe_i_q    <= cbe_i_d;
            par_i_q    <= par_i_d;
            ctl_i_q    <= ctl_i_d;
            perr_i_q   <= perr_i_d;
            ad_out_q   <= ad_out_d;
            ad_t_q     <= ad_t_d;
            cbe_out_q  <= cbe_out_d;
            cbe_t_q    <= cbe_t_d;
            par_out_q  <= par_out_d;
            par_t_q    <= par_t_d;
            chk_vld_q  <= chk_vld_d;
            chk_par_q  <= chk_par_d;
            perr_det_q <= perr_det_d;
            perr_cnt_q <= perr_cnt_d;
            perr_out_q <= perr_out_d;
            perr_t_q   <= perr_t_d;
        end
    end

    // Control-line state and output registers; reset floats every line with no park
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NCTL); i++) begin
                ctl_st_q[i] <= CTL_FLOAT;
            end
            ctl_out_q <= '1;
            ctl_t_q   <= '1;
        end else begin
            for (int i = 0; i < int'(NCTL); i++) begin
                ctl_st_q[i] <= ctl_st_d[i];
            end
            ctl_out_q <= ctl_out_d;
            ctl_t_q   <= ctl_t_d;
        end
    end

    assign pad.AD_OUT   = ad_out_q;
    assign pad.AD_T     = ad_t_q;
    assign pad.CBE_OUT  = cbe_out_q;
    assign pad.CBE_T    = cbe_t_q;
    assign pad.PAR_OUT  = par_out_q;
    assign pad.PAR_T    = par_t_q;
    assign pad.CTL_OUT  = ctl_out_q;
    assign pad.CTL_T    = ctl_t_q;
    assign pad.PERR_OUT = perr_out_q;
    assign pad.PERR_T   = perr_t_q;

    assign AD_I     = ad_i_q;
    assign CBE_I_N  = cbe_i_q;
    assign PAR_I    = par_i_q;
    assign CTL_I_N  = ctl_i_q;
    assign PERR_I_N = perr_i_q;
    assign PERR_DET = perr_det_q;
    assign PERR_CNT = perr_cnt_q;

endmodule

// File: tb/tb_pci_io_regs.sv
// Directed bench for pci_io_regs: a 32-bit instance (8-bit counter) and a 64-bit instance (2-bit counter).
module tb_pci_io_regs;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // 32-bit instance signals
    logic [31:0] ad_i_32, ad_o_32;
    logic [3:0]  cbe_i_n_32, cbe_o_n_32;
    logic [0:0]  par_i_32;
    logic [4:0]  ctl_i_n_32, ctl_o_n_32, oe_ctl_n_32;
    logic        perr_i_n_32, oe_ad_n_32, oe_cbe_n_32;
    logic        par_chk_en_32, perr_en_32, perr_cnt_clr_32, perr_det_32;
    logic [7:0]  perr_cnt_32;

    // 64-bit instance signals
    logic [63:0] ad_i_64, ad_o_64;
    logic [7:0]  cbe_i_n_64, cbe_o_n_64;
    logic [1:0]  par_i_64;
    logic [4:0]  ctl_i_n_64, ctl_o_n_64, oe_ctl_n_64;
    logic        perr_i_n_64, oe_ad_n_64, oe_cbe_n_64;
    logic        par_chk_en_64, perr_en_64, perr_cnt_clr_64, perr_det_64;
    logic [1:0]  perr_cnt_64;

    pci_io_regs_if #(.AD_WIDTH(32), .NCTL(5)) p32 ();
    pci_io_regs_if #(.AD_WIDTH(64), .NCTL(5)) p64 ();

    pci_io_regs #(.AD_WIDTH(32), .NCTL(5), .CNT_WIDTH(8)) u_d32 (
        .CLK(clk), .RST(rst), .pad(p32),
        .AD_I(ad_i_32), .CBE_I_N(cbe_i_n_32), .PAR_I(par_i_32), .CTL_I_N(ctl_i_n_32),
        .PERR_I_N(perr_i_n_32), .AD_O(ad_o_32), .OE_AD_N(oe_ad_n_32),
        .CBE_O_N(cbe_o_n_32), .OE_CBE_N(oe_cbe_n_32), .CTL_O_N(ctl_o_n_32),
        .OE_CTL_N(oe_ctl_n_32), .PAR_CHK_EN(par_chk_en_32), .PERR_EN(perr_en_32),
        .PERR_CNT_CLR(perr_cnt_clr_32), .PERR_DET(perr_det_32), .PERR_CNT(perr_cnt_32)
    );

    pci_io_regs #(.AD_WIDTH(64), .NCTL(5), .CNT_WIDTH(2)) u_d64 (
        .CLK(clk), .RST(rst), .pad(p64),
        .AD_I(ad_i_64), .CBE_I_N(cbe_i_n_64), .PAR_I(par_i_64), .CTL_I_N(ctl_i_n_64),
        .PERR_I_N(perr_i_n_64), .AD_O(ad_o_64), .OE_AD_N(oe_ad_n_64),
        .CBE_O_N(cbe_o_n_64), .OE_CBE_N(oe_cbe_n_64), .CTL_O_N(ctl_o_n_64),
        .OE_CTL_N(oe_ctl_n_64), .PAR_CHK_EN(par_chk_en_64), .PERR_EN(perr_en_64),
        .PERR_CNT_CLR(perr_cnt_clr_64), .PERR_DET(perr_det_64), .PERR_CNT(perr_cnt_64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ad_o_32 = '0; cbe_o_n_32 = '1; oe_ad_n_32 = 1'b1; oe_cbe_n_32 = 1'b1;
        ctl_o_n_32 = '1; oe_ctl_n_32 = '1; par_chk_en_32 = 1'b0; perr_en_32 = 1'b1;
        perr_cnt_clr_32 = 1'b0;
        p32.AD_IN = '0; p32.CBE_IN = '0; p32.PAR_IN = '0; p32.CTL_IN = '1; p32.PERR_IN = 1'b1;
        ad_o_64 = '0; cbe_o_n_64 = '1; oe_ad_n_64 = 1'b1; oe_cbe_n_64 = 1'b1;
        ctl_o_n_64 = '1; oe_ctl_n_64 = '1; par_chk_en_64 = 1'b0; perr_en_64 = 1'b1;
        perr_cnt_clr_64 = 1'b0;
        p64.AD_IN = '0; p64.CBE_IN = '0; p64.PAR_IN = '0; p64.CTL_IN = '1; p64.PERR_IN = 1'b1;
    endtask

    // Present one received data phase on the 32-bit pads; returns in the compare cycle
    task automatic phase32(input logic [31:0] ad, input logic [3:0] cbe, input logic par);
        p32.AD_IN = ad; p32.CBE_IN = cbe;
        tick();
        p32.PAR_IN = par; par_chk_en_32 = 1'b1;
        tick();
        par_chk_en_32 = 1'b0;
    endtask

    task automatic phase64(input logic [63:0] ad, input logic [7:0] cbe, input logic [1:0] par);
        p64.AD_IN = ad; p64.CBE_IN = cbe;
        tick();
        p64.PAR_IN = par; par_chk_en_64 = 1'b1;
        tick();
        par_chk_en_64 = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        oe_ad_n_32 = 1'b0; oe_cbe_n_32 = 1'b0; oe_ctl_n_32 = '0; ctl_o_n_32 = '0;
        ad_o_32 = 32'h1234_5678; oe_ad_n_64 = 1'b0;
        tick(); tick();
        total++; if (p32.AD_T !== 1'b0) begin bad++; $display("FAIL pre_rst_ad_t got=%h exp=0", p32.AD_T); end
        total++; if (p32.CTL_T !== 5'h00) begin bad++; $display("FAIL pre_rst_ctl_t got=%h exp=00", p32.CTL_T); end
        total++; if (p32.AD_OUT !== 32'h1234_5678) begin bad++; $display("FAIL pre_rst_ad_out got=%h exp=12345678", p32.AD_OUT); end
        rst = 1'b1;
        tick();
        total++; if ({p32.AD_T, p32.CBE_T, p32.PAR_T, p32.PERR_T} !== 4'hF) begin bad++; $display("FAIL rst_t32 got=%b exp=1111", {p32.AD_T, p32.CBE_T, p32.PAR_T, p32.PERR_T}); end
        total++; if (p32.CTL_T !== 5'h1F) begin bad++; $display("FAIL rst_ctl_t got=%h exp=1f", p32.CTL_T); end
        total++; if (p32.CTL_OUT !== 5'h1F) begin bad++; $display("FAIL rst_ctl_out got=%h exp=1f", p32.CTL_OUT); end
        total++; if (p32.CBE_OUT !== 4'hF) begin bad++; $display("FAIL rst_cbe_out got=%h exp=f", p32.CBE_OUT); end
        total++; if (p32.AD_OUT !== 32'h0) begin bad++; $display("FAIL rst_ad_out got=%h exp=0", p32.AD_OUT); end
        total++; if ({p32.PAR_OUT, p32.PERR_OUT} !== 2'b01) begin bad++; $display("FAIL rst_par_perr_out got=%b exp=01", {p32.PAR_OUT, p32.PERR_OUT}); end
        total++; if (ad_i_32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_ad_i got=%h exp=ffffffff", ad_i_32); end
        total++; if ({cbe_i_n_32, par_i_32, ctl_i_n_32, perr_i_n_32} !== 11'h7FF) begin bad++; $display("FAIL rst_core_in got=%h exp=7ff", {cbe_i_n_32, par_i_32, ctl_i_n_32, perr_i_n_32}); end
        total++; if ({perr_det_32, perr_cnt_32} !== 9'h000) begin bad++; $display("FAIL rst_perr32 got=%h exp=000", {perr_det_32, perr_cnt_32}); end
        total++; if (p64.AD_T !== 1'b1) begin bad++; $display("FAIL rst_ad_t64 got=%h exp=1", p64.AD_T); end
        total++; if ({p64.CBE_OUT, p64.PAR_OUT, par_i_64} !== 12'hFF3) begin bad++; $display("FAIL rst_64_vals got=%h exp=ff3", {p64.CBE_OUT, p64.PAR_OUT, par_i_64}); end
        total++; if (perr_cnt_64 !== 2'd0) begin bad++; $display("FAIL rst_cnt64 got=%h exp=0", perr_cnt_64); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_input_path();
        p32.AD_IN = 32'hA5A5_1234; p32.CBE_IN = 4'h6; p32.PAR_IN = 1'b1;
        p32.CTL_IN = 5'h0A; p32.PERR_IN = 1'b0;
        p64.AD_IN = 64'hDEAD_BEEF_0123_4567; p64.CBE_IN = 8'h5C; p64.PAR_IN = 2'b10;
        tick();
        total++; if (ad_i_32 !== 32'hA5A5_1234) begin bad++; $display("FAIL in_ad32 got=%h exp=a5a51234", ad_i_32); end
        total++; if ({cbe_i_n_32, par_i_32, ctl_i_n_32, perr_i_n_32} !== {4'h6, 1'b1, 5'h0A, 1'b0}) begin bad++; $display("FAIL in_ctl32 got=%h exp=%h", {cbe_i_n_32, par_i_32, ctl_i_n_32, perr_i_n_32}, {4'h6, 1'b1, 5'h0A, 1'b0}); end
        total++; if ({ad_i_64, cbe_i_n_64, par_i_64} !== {64'hDEAD_BEEF_0123_4567, 8'h5C, 2'b10}) begin bad++; $display("FAIL in_64 got=%h", {ad_i_64, cbe_i_n_64, par_i_64}); end
        p32.CTL_IN = 5'h15; p32.PERR_IN = 1'b1;
        tick();
        total++; if ({ctl_i_n_32, perr_i_n_32} !== {5'h15, 1'b1}) begin bad++; $display("FAIL in_ctl32_b got=%h exp=%h", {ctl_i_n_32, perr_i_n_32}, {5'h15, 1'b1}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_par_gen();
        ad_o_32 = 32'h0000_0001; cbe_o_n_32 = 4'h0; oe_ad_n_32 = 1'b0; oe_cbe_n_32 = 1'b0;
        tick();
        total++; if ({p32.AD_T, p32.CBE_T, p32.PAR_T} !== 3'b001) begin bad++; $display("FAIL pg_c1_t got=%b exp=001", {p32.AD_T, p32.CBE_T, p32.PAR_T}); end
        total++; if ({p32.AD_OUT, p32.CBE_OUT} !== {32'h1, 4'h0}) begin bad++; $display("FAIL pg_c1_out got=%h", {p32.AD_OUT, p32.CBE_OUT}); end
        oe_ad_n_32 = 1'b1; oe_cbe_n_32 = 1'b1; ad_o_32 = '0; cbe_o_n_32 = 4'hF;
        tick();
        total++; if ({p32.PAR_OUT, p32.PAR_T, p32.AD_T} !== 3'b101) begin bad++; $display("FAIL pg_c2 par/par_t/ad_t got=%b exp=101", {p32.PAR_OUT, p32.PAR_T, p32.AD_T}); end
        tick();
        total++; if ({p32.PAR_OUT, p32.PAR_T} !== 2'b01) begin bad++; $display("FAIL pg_c3 par/par_t got=%b exp=01", {p32.PAR_OUT, p32.PAR_T}); end
        // two consecutive data phases: 6 ones -> 0, 33 ones -> 1
        ad_o_32 = 32'h8000_0003; cbe_o_n_32 = 4'h7; oe_ad_n_32 = 1'b0;
        tick();
        ad_o_32 = 32'hFFFF_FFFF; cbe_o_n_32 = 4'h1;
        tick();
        total++; if ({p32.PAR_OUT, p32.PAR_T} !== 2'b00) begin bad++; $display("FAIL pg_b2b_a got=%b exp=00", {p32.PAR_OUT, p32.PAR_T}); end
        oe_ad_n_32 = 1'b1; ad_o_32 = '0; cbe_o_n_32 = 4'hF;
        tick();
        total++; if ({p32.PAR_OUT, p32.PAR_T} !== 2'b10) begin bad++; $display("FAIL pg_b2b_b got=%b exp=10", {p32.PAR_OUT, p32.PAR_T}); end
        tick();
        total++; if ({p32.PAR_OUT, p32.PAR_T} !== 2'b01) begin bad++; $display("FAIL pg_b2b_end got=%b exp=01", {p32.PAR_OUT, p32.PAR_T}); end
        // 64-bit: lane 0 has two ones (0), lane 1 has one (1)
        ad_o_64 = 64'h0000_0001_0000_0003; cbe_o_n_64 = 8'h00; oe_ad_n_64 = 1'b0;
        tick();
        oe_ad_n_64 = 1'b1; ad_o_64 = '0; cbe_o_n_64 = 8'hFF;
        tick();
        total++; if ({p64.PAR_OUT, p64.PAR_T} !== 3'b100) begin bad++; $display("FAIL pg64 got=%b exp=100", {p64.PAR_OUT, p64.PAR_T}); end
        tick();
        total++; if (p64.PAR_T !== 1'b1) begin bad++; $display("FAIL pg64_end par_t got=%b exp=1", p64.PAR_T); end
    endtask

    task automatic test_park();
        ctl_o_n_32 = 5'h00; oe_ctl_n_32 = 5'h1E;
        tick();
        total++; if ({p32.CTL_T, p32.CTL_OUT[0]} !== {5'h1E, 1'b0}) begin bad++; $display("FAIL pk_drive got=%h exp=%h", {p32.CTL_T, p32.CTL_OUT[0]}, {5'h1E, 1'b0}); end
        oe_ctl_n_32 = 5'h1F;
        tick();
        total++; if ({p32.CTL_T, p32.CTL_OUT[0]} !== {5'h1E, 1'b1}) begin bad++; $display("FAIL pk_park got=%h exp=%h", {p32.CTL_T, p32.CTL_OUT[0]}, {5'h1E, 1'b1}); end
        tick();
        total++; if (p32.CTL_T !== 5'h1F) begin bad++; $display("FAIL pk_float got=%h exp=1f", p32.CTL_T); end
        // re-assert the enable during park: straight back to drive
        oe_ctl_n_32 = 5'h1E;
        tick();
        oe_ctl_n_32 = 5'h1F;
        tick();
        total++; if ({p32.CTL_T[0], p32.CTL_OUT[0]} !== 2'b01) begin bad++; $display("FAIL pk_park2 got=%b exp=01", {p32.CTL_T[0], p32.CTL_OUT[0]}); end
        oe_ctl_n_32 = 5'h1E;
        tick();
        total++; if ({p32.CTL_T[0], p32.CTL_OUT[0]} !== 2'b00) begin bad++; $display("FAIL pk_redrive got=%b exp=00", {p32.CTL_T[0], p32.CTL_OUT[0]}); end
        ctl_o_n_32 = 5'h01;
        tick();
        total++; if ({p32.CTL_T[0], p32.CTL_OUT[0]} !== 2'b01) begin bad++; $display("FAIL pk_drive_hi got=%b exp=01", {p32.CTL_T[0], p32.CTL_OUT[0]}); end
        oe_ctl_n_32 = 5'h1F; ctl_o_n_32 = 5'h1F;
        tick(); tick();
        total++; if (p32.CTL_T !== 5'h1F) begin bad++; $display("FAIL pk_float2 got=%h exp=1f", p32.CTL_T); end
    endtask

    task automatic test_parity_check32();
        phase32(32'h0000_0007, 4'h0, 1'b1);
        tick();
        total++; if ({perr_det_32, p32.PERR_T, perr_cnt_32} !== {1'b0, 1'b1, 8'd0}) begin bad++; $display("FAIL pc32_good got=%h", {perr_det_32, p32.PERR_T, perr_cnt_32}); end
        phase32(32'h0000_0007, 4'h0, 1'b0);
        tick();
        total++; if ({perr_det_32, p32.PERR_OUT, p32.PERR_T} !== 3'b100) begin bad++; $display("FAIL pc32_err got=%b exp=100", {perr_det_32, p32.PERR_OUT, p32.PERR_T}); end
        total++; if (perr_cnt_32 !== 8'd1) begin bad++; $display("FAIL pc32_cnt1 got=%0d exp=1", perr_cnt_32); end
        tick();
        total++; if ({perr_det_32, p32.PERR_OUT, p32.PERR_T} !== 3'b010) begin bad++; $display("FAIL pc32_park got=%b exp=010", {perr_det_32, p32.PERR_OUT, p32.PERR_T}); end
        tick();
        total++; if ({p32.PERR_OUT, p32.PERR_T} !== 2'b11) begin bad++; $display("FAIL pc32_rel got=%b exp=11", {p32.PERR_OUT, p32.PERR_T}); end
        // response disabled: detect and count, but PERR# stays released
        perr_en_32 = 1'b0;
        phase32(32'h0000_0100, 4'h3, 1'b0);
        tick();
        total++; if ({perr_det_32, p32.PERR_OUT, p32.PERR_T, perr_cnt_32} !== {3'b111, 8'd2}) begin bad++; $display("FAIL pc32_noen got=%h", {perr_det_32, p32.PERR_OUT, p32.PERR_T, perr_cnt_32}); end
        perr_en_32 = 1'b1;
        // wrong parity without the check enable is ignored
        p32.AD_IN = '0; p32.CBE_IN = 4'h1;
        tick();
        p32.PAR_IN = 1'b0;
        tick(); tick();
        total++; if ({perr_det_32, perr_cnt_32} !== {1'b0, 8'd2}) begin bad++; $display("FAIL pc32_nochk got=%h", {perr_det_32, perr_cnt_32}); end
    endtask

    task automatic test_parity_check64();
        // all-ones upper lane has even parity, so PAR=00 is correct here
        phase64(64'hFFFF_FFFF_0000_0000, 8'h00, 2'b00);
        tick();
        total++; if ({perr_det_64, perr_cnt_64} !== 3'b000) begin bad++; $display("FAIL pc64_good got=%b exp=000", {perr_det_64, perr_cnt_64}); end
        phase64(64'h0000_0001_0000_0000, 8'h00, 2'b00);
        tick();
        total++; if ({perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64} !== 5'b10001) begin bad++; $display("FAIL pc64_lane1 got=%b exp=10001", {perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64}); end
        tick();
        total++; if ({perr_det_64, p64.PERR_OUT, p64.PERR_T} !== 3'b010) begin bad++; $display("FAIL pc64_park got=%b exp=010", {perr_det_64, p64.PERR_OUT, p64.PERR_T}); end
        tick();
        total++; if (p64.PERR_T !== 1'b1) begin bad++; $display("FAIL pc64_rel got=%b exp=1", p64.PERR_T); end
        phase64(64'h0, 8'h01, 2'b01);
        tick();
        total++; if ({perr_det_64, perr_cnt_64} !== 3'b001) begin bad++; $display("FAIL pc64_cbe_good got=%b exp=001", {perr_det_64, perr_cnt_64}); end
        phase64(64'h0, 8'h10, 2'b00);
        tick();
        total++; if ({perr_det_64, perr_cnt_64} !== 3'b110) begin bad++; $display("FAIL pc64_cbe_lane1 got=%b exp=110", {perr_det_64, perr_cnt_64}); end
        tick(); tick();
    endtask

    task automatic test_saturate_clear();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        perr_cnt_clr_64 = 1'b1;
        tick();
        perr_cnt_clr_64 = 1'b0;
        total++; if (perr_cnt_64 !== 2'd0) begin bad++; $display("FAIL sat_clr got=%0d exp=0", perr_cnt_64); end
        p64.AD_IN = 64'h1; p64.CBE_IN = 8'h00;
        tick();
        p64.PAR_IN = 2'b00; par_chk_en_64 = 1'b1;
        tick();
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 3) par_chk_en_64 = 1'b0;
            total++; if ({perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64} !== {3'b100, exp_cnt[j]}) begin bad++; $display("FAIL sat_err%0d got=%b exp=%b", j, {perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64}, {3'b100, exp_cnt[j]}); end
        end
        tick();
        total++; if ({perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64} !== 5'b01011) begin bad++; $display("FAIL sat_park got=%b exp=01011", {perr_det_64, p64.PERR_OUT, p64.PERR_T, perr_cnt_64}); end
        tick();
        total++; if (p64.PERR_T !== 1'b1) begin bad++; $display("FAIL sat_rel got=%b exp=1", p64.PERR_T); end
        // clear coinciding with an error wins
        phase64(64'h1, 8'h00, 2'b00);
        perr_cnt_clr_64 = 1'b1;
        tick();
        perr_cnt_clr_64 = 1'b0;
        total++; if ({perr_det_64, perr_cnt_64} !== 3'b100) begin bad++; $display("FAIL clr_vs_err got=%b exp=100", {perr_det_64, perr_cnt_64}); end
        tick();
        phase64(64'h1, 8'h00, 2'b00);
        tick();
        total++; if ({perr_det_64, perr_cnt_64} !== 3'b101) begin bad++; $display("FAIL clr_resume got=%b exp=101", {perr_det_64, perr_cnt_64}); end
    endtask

    initial begin
        test_reset();
        test_input_path();
        test_par_gen();
        test_park();
        test_parity_check32();
        test_parity_check64();
        test_saturate_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
